// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parameter legality.
// Used by the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    // True when a parameter set describes a buildable UART.
    function automatic bit params_ok(
        input int data_w,
        input int stop_bits,
        input int clks_per_bit,
        input int parity_odd
    );
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
               (stop_bits == 1 || stop_bits == 2) &&
               (clks_per_bit >= 2) &&
               (parity_odd == 0 || parity_odd == 1);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick on terminal count.
// Synchronous clear holds it at zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Free-running period count, wrapping on terminal count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter (start, DATA_W bits LSB first, stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit after the data MSB.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_in,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (!params_ok(DATA_W, STOP_BITS, CLKS_PER_BIT, PARITY_ODD)) begin : g_bad_params
            $error("uart_tx_frame: illegal DATA_W/STOP_BITS/CLKS_PER_BIT/PARITY_ODD");
        end
    endgenerate

    uart_state_t       state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              stop_cnt;
    logic              tick;
    logic              baud_clr;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif

    // Counter only runs inside a frame; every in-frame state change lands on a wrap.
    assign baud_clr = (state == S_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clr),
        .tick (tick)
    );

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        shreg    <= d_in;
                        idx      <= '0;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        par      <= (^d_in) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state   <= S_IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLKS_PER_BIT=4, DATA_W=8.
// Two instances: 1 stop bit even parity, 2 stop bits odd parity.
module tb_uart_tx_frame;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        bit       which;
        bit [7:0] d;
        bit       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d_in = 8'h00;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       busy_a, done_a, tx_a;
    logic       busy_b, done_b, tx_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .reset(reset), .d_in(d_in), .tx_start(start_a),
        .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a)
    );

    uart_tx_frame #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)
    ) dut_b (
        .clk(clk), .reset(reset), .d_in(d_in), .tx_start(start_b),
        .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_idle(input string name, input bit which);
        check({name, " tx"},   which ? tx_b : tx_a,     1'b1);
        check({name, " busy"}, which ? busy_b : busy_a, 1'b0);
        check({name, " done"}, which ? done_b : done_a, 1'b0);
    endtask

    function automatic logic exp_bit(input bit [7:0] d, input bit par, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (P == 1 && slot == 9) return par;
        return 1'b1;
    endfunction

    // Called just after the accepting edge n; ends at the negedge after edge n+F.
    task automatic check_frame(input bit which, input bit [7:0] d, input bit par);
        int stops = which ? 2 : 1;
        int f = (1 + 8 + P + stops) * CPB;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            check($sformatf("bit%0d tx", k / CPB), which ? tx_b : tx_a, exp_bit(d, par, k / CPB));
            check("busy in frame", which ? busy_b : busy_a, 1'b1);
            check("done in frame", which ? done_b : done_a, 1'b0);
        end
        @(negedge clk);
        check("end done", which ? done_b : done_a, 1'b1);
        check("end busy", which ? busy_b : busy_a, 1'b0);
        check("end tx", which ? tx_b : tx_a, 1'b1);
    endtask

    task automatic accept(input bit which, input bit [7:0] d);
        @(negedge clk);
        d_in = d;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    vec_t vecs[4];
    int   dones;

    initial begin
        vecs[0] = '{which: 1'b0, d: 8'hF0, par: 1'b0};
        vecs[1] = '{which: 1'b1, d: 8'hA5, par: 1'b1};
        vecs[2] = '{which: 1'b0, d: 8'h01, par: 1'b1};
        vecs[3] = '{which: 1'b1, d: 8'h3F, par: 1'b1};

        // Reset with start held: must stay idle.
        start_a = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset a", 1'b0);
            check_idle("reset b", 1'b1);
        end
        reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check_idle("post reset", 1'b0);

        // Table-driven frames.
        foreach (vecs[i]) begin
            accept(vecs[i].which, vecs[i].d);
            check_frame(vecs[i].which, vecs[i].d, vecs[i].par);
            @(negedge clk);
            check("done one cycle", vecs[i].which ? done_b : done_a, 1'b0);
        end

        // Back-to-back with tx_start held, d_in changed mid-frame.
        @(negedge clk);
        d_in = 8'h55;
        start_a = 1'b1;
        @(posedge clk);
        fork
            begin
                repeat (10) @(posedge clk);
                #1 d_in = 8'h00;
            end
        join_none
        check_frame(1'b0, 8'h55, 1'b0);
        @(posedge clk);
        #1 start_a = 1'b0;
        check_frame(1'b0, 8'h00, 1'b0);

        // Start pulse while busy is ignored.
        accept(1'b0, 8'hC3);
        fork
            begin
                repeat (9) @(posedge clk);
                #1 start_a = 1'b1;
                @(posedge clk);
                #1 start_a = 1'b0;
            end
        join_none
        check_frame(1'b0, 8'hC3, 1'b0);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a) dones++;
            check("no second frame tx", tx_a, 1'b1);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL extra done: got %0d expected 0", dones);
        end

        // Reset mid-frame aborts, then a clean frame follows.
        accept(1'b0, 8'hF0);
        repeat (13) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid reset", 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("after abort", 1'b0);
        end
        accept(1'b0, 8'h07);
        check_frame(1'b0, 8'h07, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 `Tx` block. Serialises a `DATA_W`-bit word onto `tx` with configurable bit period, data width and stop-bit count, plus optional compiled-in parity. Sits between the core's byte source (FIFO or FSM) and the board TX pin, on the single system clock. Uses the same start/done handshake as `Tx` and adds a `tx_busy` status.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, 868: clocks per bit period; must be ≥2. The default gives 115200 baud at 100 MHz.
- `STOP_BITS`, 1: stop bits per frame; must be 1 or 2.
- `PARITY_ODD`, 0: parity sense; 0 = even, 1 = odd. Only used when `UART_TX_PARITY_EN` is defined.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `d_in`  in  DATA_W  word to send; sampled only in the cycle a start is accepted.
- `tx_start`  in  1  start request; level-sampled while IDLE.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when a frame completes.
- `tx`  out  1  serial line; idles high; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only if the macro is defined), STOP.
- IDLE:
  - If `tx_start` is high, latch `d_in` into the shift register, clear the baud counter, go to START.
  - Otherwise remain in IDLE.
- START: drive `tx`=0 for one bit period.
- DATA: send bits LSB first, one bit period each. The bit index runs 0..`DATA_W`-1.
- PARITY: send `^data` (even) or `~^data` (odd) for one bit period.
- STOP: drive `tx`=1 for `STOP_BITS` bit periods, then go to IDLE.
- `tx_done` is asserted in the single cycle the FSM enters IDLE from STOP.
- Baud counter:
  - `$clog2(CLKS_PER_BIT)` bits wide.
  - Counts 0..`CLKS_PER_BIT`-1; the bit advances on terminal count.
  - Cleared on every state change.
- Bit-index width is `$clog2(DATA_W)`. Stop counter is 1 bit.
- `tx_start` while busy is ignored; no queueing. `d_in` changes mid-frame have no effect.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, all counters 0.
- Reset mid-frame: abort. `tx`=1 after the reset edge, no `tx_done`, no partial bits afterwards.
- Reset and `tx_start` both high: reset wins; the start is dropped.

## Timing
- Frame length F = (1 + `DATA_W` + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P=1 with parity and 0 without.
- Start accepted at edge n:
  - `tx`=0 and `tx_busy`=1 from edge n.
  - Each bit holds for exactly `CLKS_PER_BIT` cycles.
- At edge n+F:
  - State=IDLE, `tx_busy`=0, `tx_done`=1 for one cycle.
  - `tx` stays 1.
- Earliest next acceptance is edge n+F+1, so continuously held `tx_start` gives frames separated by one extra idle clock.
- No combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists and one parity bit is inserted after the data MSB.
  - `PARITY_ODD` selects the sense.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state, frame is start/data/stop only.
  - `PARITY_ODD` is ignored. The timing is bit-identical to 8N1 `Tx` at default parameters.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP).
  - Parameter-legality checks (DATA_W range, STOP_BITS∈{1,2}, CLKS_PER_BIT≥2) as elaboration-time errors.
  - Reused by the future receiver.
- One sub-module, `uart_baud_cnt`:
  - Parametrised bit-period counter with synchronous `clear` input and `tick` output.
  - Shared with the receiver.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `DATA_W`=8, `STOP_BITS`=1 unless stated.
- **Reset:** hold `reset` 3 cycles → `tx`=1, `tx_busy`=0, `tx_done`=0; `tx_start`=1 during reset is ignored.
- **Basic frame, no parity:** `d_in`=8'hF0, `tx_start` pulsed 1 cycle → `tx` bits 0, 0,0,0,0,1,1,1,1, 1, each held 4 clks. `tx_done` pulses at cycle 40, `tx_busy` is high for cycles 0..39.
- **Parity, macro on:** `PARITY_ODD`=0 with `d_in`=8'hF0 → parity bit 0, F=44. `PARITY_ODD`=1, `STOP_BITS`=2 with `d_in`=8'hA5 → parity bit 1, stop high for 8 clks, F=48.
- **Back-to-back:** `tx_start` held high, `d_in`=8'h55, then changed to 8'h00 mid-frame → first frame carries 8'h55; the second starts exactly one clock after `tx_done`.
- **Start while busy:** `tx_start` pulse at cycle 10 of a frame → ignored; exactly one `tx_done` and no second frame.
- **Reset mid-frame:** `reset` at cycle 14 → `tx`=1 next cycle, no `tx_done`. A new start at cycle 20 sends a correct full frame.
